relm_div_seq: RTL

RELM_DIV_SEQ -- requirements
Module: relm_div_seq

---
 rtl/relm_div_pkg.sv | 15 +
 rtl/relm_div_seq_if.sv | 32 +++
 rtl/relm_lower.sv | 20 ++
 rtl/relm_div_seq.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/relm_div_pkg.sv
// relm_div_pkg: shared definitions for the sequential radix-4 divider.
//   WD_DEFAULT : default operand/result width
//   state_e    : FSM state encoding (IDLE=0, INIT=1, LOOP=2, DONE=3)
package relm_div_pkg;

  localparam int WD_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    INIT = 2'd1,
    LOOP = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/relm_div_seq_if.sv
// relm_div_seq_if: request/result bundle of the divider.
//   master : drives start_in, n_in, d_in; observes results
//   slave  : the divider side
// Handshake: start_in is a request strobe sampled only while busy_out is
// low; done_out is a one-cycle pulse marking the cycle in which q_out,
// r_out and div0_out first show the new result. There is no back-pressure.
interface relm_div_seq_if
  import relm_div_pkg::*;
#(
  parameter int WD = WD_DEFAULT
);

  logic          start_in;
  logic [WD-1:0] n_in;
  logic [WD-1:0] d_in;
  logic          busy_out;
  logic          done_out;
  logic [WD-1:0] q_out;
  logic [WD-1:0] r_out;
  logic          div0_out;

  modport master (
    output start_in, n_in, d_in,
    input  busy_out, done_out, q_out, r_out, div0_out
  );

  modport slave (
    input  start_in, n_in, d_in,
    output busy_out, done_out, q_out, r_out, div0_out
  );

endinterface

// File: rtl/relm_lower.sv
// relm_lower: leading-one smear. Every bit at or below the most significant
// set bit of in_val is set in smear_out; zero input gives zero output.
//   in_val    : WD-bit value
//   smear_out : WD-bit smeared value
module relm_lower #(
  parameter int WD = 32
) (
  input  logic [WD-1:0] in_val,
  output logic [WD-1:0] smear_out
);

  always_comb begin
    smear_out = '0;
    smear_out[WD-1] = in_val[WD-1];
    for (int i = WD - 2; i >= 0; i--) begin
      smear_out[i] = smear_out[i+1] | in_val[i];
    end
  end

endmodule

// File: rtl/relm_div_seq.sv
// relm_div_seq: sequential unsigned divider, two quotient bits per cycle.
//   clk, rst_n      : clock, asynchronous active-low reset
//   start_in        : request, sampled only in IDLE, with n_in / d_in
//   busy_out        : high whenever the FSM is not in IDLE
//   done_out        : one-cycle pulse when q_out / r_out / div0_out update
//   q_out, r_out    : quotient and remainder, held until the next result
//   div0_out        : last operation had a zero divisor
//   state_dbg_out   : current FSM state, for observation only
module relm_div_seq
  import relm_div_pkg::*;
#(
  parameter int WD = WD_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start_in,
  input  logic [WD-1:0] n_in,
  input  logic [WD-1:0] d_in,
  output logic          busy_out,
  output logic          done_out,
  output logic [WD-1:0] q_out,
  output logic [WD-1:0] r_out,
  output logic          div0_out,
  output state_e        state_dbg_out
);

  localparam int KW = $clog2(WD) + 1;
  localparam logic [WD-1:0] ONE = {{(WD-1){1'b0}}, 1'b1};

  state_e        state_q, state_d;
  logic [WD-1:0] n_q, n_d;          // captured dividend
  logic [WD-1:0] d_q, d_d;          // captured divisor
  logic [WD-1:0] r_q, r_d;          // running remainder
  logic [WD-1:0] acc_q, acc_d;      // running quotient
  logic [WD-1:0] qbit_q, qbit_d;    // weight of the current high quotient bit
  logic [WD-1:0] dq_q, dq_d;        // divisor aligned to qbit
  logic          z_q, z_d;          // zero-divisor flag of the operation in flight
  logic [WD-1:0] q_out_q, q_out_d;
  logic [WD-1:0] r_out_q, r_out_d;
  logic          div0_out_q, div0_out_d;
  logic          done_q, done_d;
  logic          busy_q, busy_d;

  logic [WD-1:0] smear_n, smear_d;
  logic [KW-1:0] k;
  logic [WD-1:0] r1, r2, acc1, acc2, dq_half;

  relm_lower #(.WD(WD)) u_lower_n (.in_val(n_q), .smear_out(smear_n));
  relm_lower #(.WD(WD)) u_lower_d (.in_val(d_q), .smear_out(smear_d));

  // Number of ones in a smear equals msb_pos + 1, so the difference of the
  // two counts is the alignment distance msb_pos(N) - msb_pos(D).
  function automatic logic [KW-1:0] ones(input logic [WD-1:0] v);
    logic [KW-1:0] c;
    c = '0;
    for (int i = 0; i < WD; i++) c = c + KW'(v[i]);
    return c;
  endfunction

  always_comb begin
    k = ones(smear_n) - ones(smear_d);

    // Radix-4 step: first the bit weighted qbit, then the one below it.
    // When qbit is already bit 0 there is no lower bit left to resolve.
    dq_half = dq_q >> 1;
    r1   = r_q;
    acc1 = acc_q;
    if (r_q >= dq_q) begin
      r1   = r_q - dq_q;
      acc1 = acc_q | qbit_q;
    end
    r2   = r1;
    acc2 = acc1;
    if (!qbit_q[0] && (r1 >= dq_half)) begin
      r2   = r1 - dq_half;
      acc2 = acc1 | (qbit_q >> 1);
    end

    state_d    = state_q;
    n_d        = n_q;
    d_d        = d_q;
    r_d        = r_q;
    acc_d      = acc_q;
    qbit_d     = qbit_q;
    dq_d       = dq_q;
    z_d        = z_q;
    q_out_d    = q_out_q;
    r_out_d    = r_out_q;
    div0_out_d = div0_out_q;
    done_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_in) begin
          n_d     = n_in;
          d_d     = d_in;
          state_d = INIT;
        end
      end
      INIT: begin
        if (smear_d == '0) begin
          acc_d   = '1;
          r_d     = n_q;
          z_d     = 1'b1;
          state_d = DONE;
        end else if (n_q < d_q) begin
          acc_d   = '0;
          r_d     = n_q;
          z_d     = 1'b0;
          state_d = DONE;
        end else begin
          // D << k cannot overflow: its msb lands exactly on N's msb.
          qbit_d  = ONE << k;
          dq_d    = d_q << k;
          r_d     = n_q;
          acc_d   = '0;
          z_d     = 1'b0;
          state_d = LOOP;
        end
      end
      LOOP: begin
        r_d    = r2;
        acc_d  = acc2;
        qbit_d = qbit_q >> 2;
        dq_d   = dq_q >> 2;
        if (qbit_q[1:0] != 2'b00) state_d = DONE;
      end
      DONE: begin
        q_out_d    = acc_q;
        r_out_d    = r_q;
        div0_out_d = z_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      n_q        <= '0;
      d_q        <= '0;
      r_q        <= '0;
      acc_q      <= '0;
      qbit_q     <= '0;
      dq_q       <= '0;
      z_q        <= 1'b0;
      q_out_q    <= '0;
      r_out_q    <= '0;
      div0_out_q <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      n_q        <= n_d;
      d_q        <= d_d;
      r_q        <= r_d;
      acc_q      <= acc_d;
      qbit_q     <= qbit_d;
      dq_q       <= dq_d;
      z_q        <= z_d;
      q_out_q    <= q_out_d;
      r_out_q    <= r_out_d;
      div0_out_q <= div0_out_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign busy_out      = busy_q;
  assign done_out      = done_q;
  assign q_out         = q_out_q;
  assign r_out         = r_out_q;
  assign div0_out      = div0_out_q;
  assign state_dbg_out = state_q;

endmodule
